// File: rtl/csel_add_sched.sv
// Two-requester scheduler sharing a single carry-select adder through an IDLE/EXEC/RESP FSM.
// Build option: CSEL_SCHED_FIXED_PRIO_EN selects fixed priority (requester 0 wins) instead of round-robin.

module C_Sel_A_45bit #(
  parameter int width = 45
) (
  input  logic [width-1:0] a,
  input  logic [width-1:0] b,
  input  logic             cin,
  output logic [width-1:0] s,
  output logic             cout
);
  localparam int blk_w = 9;
  localparam int n_blk = (width + blk_w - 1) / blk_w;

  logic [n_blk-1:0] blk_co0;
  logic [n_blk-1:0] blk_co1;
  logic [n_blk-1:0] blk_ci;

  genvar gi;
  generate
    for (gi = 0; gi < n_blk; gi++) begin : g_blk
      localparam int lo = gi * blk_w;
      localparam int nb = ((width - lo) < blk_w) ? (width - lo) : blk_w;
      logic [nb:0] sum0;
      logic [nb:0] sum1;
      // Each block precomputes both carry-in outcomes; the real carry only picks one.
      assign sum0 = {1'b0, a[lo +: nb]} + {1'b0, b[lo +: nb]};
      assign sum1 = {1'b0, a[lo +: nb]} + {1'b0, b[lo +: nb]} + (nb + 1)'(1);
      assign blk_co0[gi] = sum0[nb];
      assign blk_co1[gi] = sum1[nb];
      assign s[lo +: nb] = blk_ci[gi] ? sum1[nb-1:0] : sum0[nb-1:0];
    end
  endgenerate

  always_comb begin
    logic c;
    c = cin;
    blk_ci = '0;
    for (int i = 0; i < n_blk; i++) begin
      blk_ci[i] = c;
      c = c ? blk_co1[i] : blk_co0[i];
    end
    cout = c;
  end
endmodule

module csel_add_sched #(
  parameter int width = 45
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [width:1]   req0_a,
  input  logic [width:1]   req0_b,
  input  logic             req0_cin,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [width:1]   req1_a,
  input  logic [width:1]   req1_b,
  input  logic             req1_cin,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [width:1]   rsp_sum,
  output logic             rsp_cout,
  output logic             rsp_id
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t           state_reg;
  logic [width:1]   a_reg;
  logic [width:1]   b_reg;
  logic             cin_reg;
  logic             id_reg;
  logic [width:1]   add_s;
  logic             add_cout;
  logic             grant_id;
  logic             accept_ok;

`ifdef CSEL_SCHED_FIXED_PRIO_EN
  assign grant_id = !req0_valid;
`else
  logic ptr_reg;
  assign grant_id = (req0_valid && req1_valid) ? !ptr_reg : req1_valid;
`endif

  // Ready depends on the live valid so a withdrawn request is never granted.
  assign accept_ok  = (state_reg == IDLE) && !rst;
  assign req0_ready = accept_ok && req0_valid && !grant_id;
  assign req1_ready = accept_ok && req1_valid && grant_id;

  C_Sel_A_45bit #(.width(width)) u_adder (
    .a    (a_reg),
    .b    (b_reg),
    .cin  (cin_reg),
    .s    (add_s),
    .cout (add_cout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
`ifndef CSEL_SCHED_FIXED_PRIO_EN
      ptr_reg   <= 1'b1;
`endif
      a_reg     <= '0;
      b_reg     <= '0;
      cin_reg   <= 1'b0;
      id_reg    <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_sum   <= '0;
      rsp_cout  <= 1'b0;
      rsp_id    <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (req0_valid || req1_valid) begin
            a_reg     <= grant_id ? req1_a : req0_a;
            b_reg     <= grant_id ? req1_b : req0_b;
            cin_reg   <= grant_id ? req1_cin : req0_cin;
            id_reg    <= grant_id;
`ifndef CSEL_SCHED_FIXED_PRIO_EN
            ptr_reg   <= grant_id;
`endif
            state_reg <= EXEC;
          end
        end
        EXEC: begin
          rsp_sum   <= add_s;
          rsp_cout  <= add_cout;
          rsp_id    <= id_reg;
          rsp_valid <= 1'b1;
          state_reg <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_csel_add_sched.sv
// Directed bench for csel_add_sched: vector table plus contention, backpressure, reset and withdrawal sequences.
// Honours CSEL_SCHED_FIXED_PRIO_EN for the contention expectation.

module tb_csel_add_sched;
  localparam int W = 45;

  logic         clk = 1'b0;
  logic         rst;
  logic         req0_valid, req0_ready, req0_cin;
  logic [W:1]   req0_a, req0_b;
  logic         req1_valid, req1_ready, req1_cin;
  logic [W:1]   req1_a, req1_b;
  logic         rsp_valid, rsp_ready, rsp_cout, rsp_id;
  logic [W:1]   rsp_sum;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       id;
    logic [W:1] a;
    logic [W:1] b;
    logic       cin;
    logic [W:1] sum;
    logic       cout;
  } vec_t;

  vec_t vecs[7];

  csel_add_sched #(.width(W)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_cin(req0_cin),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_cin(req1_cin),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_sum(rsp_sum), .rsp_cout(rsp_cout), .rsp_id(rsp_id)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic drive_req(input logic id, input logic [W:1] a, input logic [W:1] b, input logic cin);
    req0_valid = !id; req0_a = a; req0_b = b; req0_cin = cin;
    req1_valid = id;  req1_a = a; req1_b = b; req1_cin = cin;
  endtask

  // Called at a negedge after driving; returns once the requester's ready is seen.
  task automatic wait_ready(input logic id, output logic ok);
    ok = 1'b0;
    for (int t = 0; t < 8; t++) begin
      #1;
      if ((id ? req1_ready : req0_ready) === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) chk("accept_timeout", 64'(0), 64'(1));
  endtask

  initial begin
    logic ok;
    logic exp_ids[4];
    int   nrsp, last_t, bad;

    vecs[0] = '{1'b0, 45'd5, 45'd7, 1'b1, 45'd13, 1'b0};
    vecs[1] = '{1'b1, 45'h1FFF_FFFF_FFFF, 45'd0, 1'b1, 45'd0, 1'b1};
    vecs[2] = '{1'b0, 45'h1000_0000_0000, 45'h1000_0000_0000, 1'b0, 45'd0, 1'b1};
    vecs[3] = '{1'b1, 45'h1FF, 45'd1, 1'b0, 45'h200, 1'b0};
    vecs[4] = '{1'b0, 45'h1FFF_FFFF_FFFF, 45'h1FFF_FFFF_FFFF, 1'b1, 45'h1FFF_FFFF_FFFF, 1'b1};
    vecs[5] = '{1'b1, 45'h123_4567_89AB, 45'h0FE_DCBA_9876, 1'b0, 45'h222_2222_2221, 1'b0};
    vecs[6] = '{1'b1, 45'd0, 45'd0, 1'b1, 45'd1, 1'b0};

    // Reset with both requests pending: nothing may be granted.
    rst = 1'b1; rsp_ready = 1'b1;
    drive_req(1'b0, 45'd1, 45'd1, 1'b0);
    req1_valid = 1'b1;
    @(negedge clk); @(negedge clk); #1;
    chk("rst_req0_ready", 64'(req0_ready), 64'(0));
    chk("rst_req1_ready", 64'(req1_ready), 64'(0));
    chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("rst_rsp_sum", 64'(rsp_sum), 64'(0));
    chk("rst_rsp_cout", 64'(rsp_cout), 64'(0));
    chk("rst_rsp_id", 64'(rsp_id), 64'(0));
    rst = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      drive_req(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].cin);
      wait_ready(vecs[i].id, ok);
      @(negedge clk);
      req0_valid = 1'b0; req1_valid = 1'b0;
      #1 chk("lat_n1_valid", 64'(rsp_valid), 64'(0));
      @(negedge clk); #1;
      chk("lat_n2_valid", 64'(rsp_valid), 64'(1));
      chk("vec_sum", 64'(rsp_sum), 64'(vecs[i].sum));
      chk("vec_cout", 64'(rsp_cout), 64'(vecs[i].cout));
      chk("vec_id", 64'(rsp_id), 64'(vecs[i].id));
      $display("txn vec %0d id=%0d sum=%h cout=%0d", i, rsp_id, rsp_sum, rsp_cout);
      @(negedge clk);
      #1 chk("vec_consumed", 64'(rsp_valid), 64'(0));
    end

    // Contention after reset with both requesters held valid.
`ifdef CSEL_SCHED_FIXED_PRIO_EN
    exp_ids = '{1'b0, 1'b0, 1'b0, 1'b0};
`else
    exp_ids = '{1'b0, 1'b1, 1'b0, 1'b1};
`endif
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; rsp_ready = 1'b1;
    req0_valid = 1'b1; req0_a = 45'd1;  req0_b = 45'd1;  req0_cin = 1'b0;
    req1_valid = 1'b1; req1_a = 45'd10; req1_b = 45'd10; req1_cin = 1'b0;
    nrsp = 0; last_t = 0;
    for (int t = 0; t < 30; t++) begin
      #1;
      if (req0_ready && req1_ready) chk("ready_onehot", 64'(1), 64'(0));
      if (rsp_valid) begin
        chk("cont_id", 64'(rsp_id), 64'(exp_ids[nrsp]));
        chk("cont_sum", 64'(rsp_sum), rsp_id ? 64'(20) : 64'(2));
        if (nrsp > 0) chk("cont_gap", 64'(t - last_t), 64'(3));
        $display("txn contention %0d id=%0d sum=%0d", nrsp, rsp_id, rsp_sum);
        last_t = t;
        nrsp++;
        if (nrsp == 4) break;
      end
      @(negedge clk);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    chk("cont_count", 64'(nrsp), 64'(4));
    @(negedge clk);

    // Backpressure: response held for five cycles with both requesters waiting.
    rsp_ready = 1'b0;
    drive_req(1'b0, 45'd100, 45'd23, 1'b0);
    wait_ready(1'b0, ok);
    @(negedge clk);
    @(negedge clk);
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int t = 0; t < 5; t++) begin
      #1;
      chk("bp_valid", 64'(rsp_valid), 64'(1));
      chk("bp_sum", 64'(rsp_sum), 64'(123));
      chk("bp_cout", 64'(rsp_cout), 64'(0));
      chk("bp_id", 64'(rsp_id), 64'(0));
      chk("bp_readies", 64'({req0_ready, req1_ready}), 64'(0));
      @(negedge clk);
    end
    rsp_ready = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0;
    #1 $display("txn backpressure id=%0d sum=%0d", rsp_id, rsp_sum);
    @(negedge clk);
    #1 chk("bp_consumed", 64'(rsp_valid), 64'(0));

    // Reset while the request is in EXEC drops it.
    drive_req(1'b0, 45'd50, 45'd50, 1'b0);
    wait_ready(1'b0, ok);
    @(negedge clk);
    rst = 1'b1; req0_valid = 1'b0;
    @(negedge clk); #1;
    chk("rstx_valid", 64'(rsp_valid), 64'(0));
    chk("rstx_sum", 64'(rsp_sum), 64'(0));
    rst = 1'b0;
    drive_req(1'b1, 45'd7, 45'd8, 1'b1);
    #1 chk("rstx_accept", 64'(req1_ready), 64'(1));
    @(negedge clk);
    req1_valid = 1'b0;
    @(negedge clk); #1;
    chk("rstx_new_valid", 64'(rsp_valid), 64'(1));
    chk("rstx_new_sum", 64'(rsp_sum), 64'(16));
    chk("rstx_new_id", 64'(rsp_id), 64'(1));
    $display("txn after_reset id=%0d sum=%0d", rsp_id, rsp_sum);
    bad = 0;
    for (int t = 0; t < 4; t++) begin
      @(negedge clk);
      #1 if (rsp_valid) bad++;
    end
    chk("rstx_no_extra", 64'(bad), 64'(0));

    // A one-cycle req1 pulse during RESP is never granted or answered.
    rsp_ready = 1'b0;
    drive_req(1'b0, 45'd3, 45'd4, 1'b0);
    wait_ready(1'b0, ok);
    @(negedge clk);
    req0_valid = 1'b0;
    @(negedge clk);
    req1_valid = 1'b1; req1_a = 45'd9; req1_b = 45'd9; req1_cin = 1'b0;
    #1 chk("wd_req1_ready", 64'(req1_ready), 64'(0));
    @(negedge clk);
    req1_valid = 1'b0; rsp_ready = 1'b1;
    #1;
    chk("wd_rsp_valid", 64'(rsp_valid), 64'(1));
    chk("wd_rsp_sum", 64'(rsp_sum), 64'(7));
    chk("wd_rsp_id", 64'(rsp_id), 64'(0));
    $display("txn withdrawn_window id=%0d sum=%0d", rsp_id, rsp_sum);
    bad = 0;
    for (int t = 0; t < 6; t++) begin
      @(negedge clk);
      #1 if (rsp_valid && rsp_id) bad++;
    end
    chk("wd_no_id1_rsp", 64'(bad), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
